// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and helpers for the 8-digit 7-segment scan controller.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 3;
  localparam int NIBBLE_W   = 4;
  localparam int VALUE_W    = 32;

  // Active-low one-hot anode pattern for digit index d (bit d low, all others high).
  function automatic logic [NUM_DIGITS-1:0] onehot_n(input logic [DIGIT_W-1:0] d);
    onehot_n = ~(NUM_DIGITS'(1) << d);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// Free-running prescaler: counts 0..PRESCALE-1 while enabled and flags the last count.
// Latency: tick is combinational from the registered count; it is high for 1 cycle every PRESCALE enabled cycles.
// Backpressure: none; en=0 freezes the count in place.
module seg_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] pre_cnt;

  assign tick = en && (pre_cnt == LAST);

  // Count while enabled and wrap after the last slot cycle; hold when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (tick) pre_cnt <= '0;
      else      pre_cnt <= pre_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans an 8-digit multiplexed 7-segment display from a tear-free shadow of a 32-bit value.
// Latency: load -> value_q at the next frame wrap while scanning (<= 8*PRESCALE cycles), 1 cycle while dark.
// Backpressure: none; a load is always accepted and a later load before the apply point overrides it.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digits (digit 0 always lit).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [VALUE_W-1:0]    value,
  output logic [DIGIT_W-1:0]    digit_sel,
  output logic [VALUE_W-1:0]    value_q,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic                  frame_tick
);

  logic                  tick;
  logic                  dark;      // mirrors "display dark" without depending on blanked slots
  logic                  pend;
  logic [VALUE_W-1:0]    pend_val;
  logic                  apply;
  logic [DIGIT_W-1:0]    digit_nxt;
  logic [VALUE_W-1:0]    vq_nxt;
  logic [NUM_DIGITS-1:0] anode_nxt;

  seg_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Next digit, shadow apply decision and next anode pattern.
  always_comb begin
    digit_nxt = tick ? digit_sel + DIGIT_W'(1) : digit_sel;
    apply     = dark || (tick && (digit_sel == DIGIT_W'(NUM_DIGITS - 1)));

    vq_nxt = value_q;
    if (apply) begin
      if (load)      vq_nxt = value;      // same-cycle load beats any older pending value
      else if (pend) vq_nxt = pend_val;
    end

    anode_nxt = en ? onehot_n(digit_nxt) : '1;
`ifdef LEADING_ZERO_BLANK_EN
    // Blank against the value being shown on the same edge so anodes and data never disagree.
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if ((vq_nxt >> (k * NIBBLE_W)) == '0) anode_nxt[k] = 1'b1;
    end
`endif
  end

  // Digit counter, frame pulse, anode register and dark flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_sel  <= '0;
      frame_tick <= 1'b0;
      anode_n    <= '1;
      dark       <= 1'b1;
    end else begin
      digit_sel  <= digit_nxt;
      frame_tick <= tick && (digit_sel == DIGIT_W'(NUM_DIGITS - 1));
      anode_n    <= anode_nxt;
      dark       <= ~en;
    end
  end

  // Shadow register with a single pending slot; last load before the apply point wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
    end else begin
      value_q <= vq_nxt;
      if (apply) begin
        pend <= 1'b0;
      end else if (load) begin
        pend     <= 1'b1;
        pend_val <= value;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [31:0] value;
  logic [2:0]  digit_sel;
  logic [31:0] value_q;
  logic [7:0]  anode_n;
  logic        frame_tick;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n;
  int d;
  logic [7:0] exp_a;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.PRESCALE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .value      (value),
    .digit_sel  (digit_sel),
    .value_q    (value_q),
    .anode_n    (anode_n),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (n=%0d)", tag, act, exp, n);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic logic [7:0] exp_an(input int dg);
    return ~(8'd1 << dg);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; n = 0;
    step(); step();
    chk("rst_digit", 32'(digit_sel), 32'd0);
    chk("rst_value", value_q, 32'd0);
    chk("rst_anode", 32'(anode_n), 32'hFF);
    chk("rst_frame", 32'(frame_tick), 32'd0);

    // 1: free-running scan
    rst = 1'b0; en = 1'b1; n = 0;
    repeat (40) begin
      step();
      chk("t1_digit", 32'(digit_sel), 32'((n / 4) % 8));
      chk("t1_anode", 32'(anode_n), 32'(exp_an((n / 4) % 8)));
      chk("t1_frame", 32'(frame_tick), 32'(n % 32 == 0));
    end

    // 2: load at digit 3, visible only at the wrap
    while (n < 45) step();
    chk("t2_at_d3", 32'(digit_sel), 32'd3);
    load = 1'b1; value = 32'h1234_5678; step(); load = 1'b0;
    while (n < 64) begin
      chk("t2_hold", value_q, 32'd0);
      step();
    end
    chk("t2_apply", value_q, 32'h1234_5678);
    chk("t2_digit0", 32'(digit_sel), 32'd0);
    chk("t2_frame", 32'(frame_tick), 32'd1);

    // 3: last load wins; load on the apply cycle goes straight through
    while (n < 69) step();
    load = 1'b1; value = 32'hAAAA_AAAA; step();
    value = 32'h5555_5555; step(); load = 1'b0;
    while (n < 95) step();
    chk("t3_pre", value_q, 32'h1234_5678);
    step();
    chk("t3_last", value_q, 32'h5555_5555);
    while (n < 99) step();
    load = 1'b1; value = 32'h1111_1111; step(); load = 1'b0;
    while (n < 127) step();
    chk("t3_hold", value_q, 32'h5555_5555);
    chk("t3_d7", 32'(digit_sel), 32'd7);
    load = 1'b1; value = 32'h0BAD_F00D; step(); load = 1'b0;
    chk("t3_same", value_q, 32'h0BAD_F00D);
    while (n < 160) step();
    chk("t3_nopend", value_q, 32'h0BAD_F00D);
    chk("t3_wrap", 32'(digit_sel), 32'd0);

    // 4: dark window at digit 5 with a load
    while (n < 181) step();
    chk("t4_d5", 32'(digit_sel), 32'd5);
    chk("t4_an5", 32'(anode_n), 32'hDF);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin load = 1'b1; value = 32'hDEAD_BEEF; end
      step();
      load = 1'b0;
      chk("t4_dark", 32'(anode_n), 32'hFF);
      chk("t4_hold", 32'(digit_sel), 32'd5);
      chk("t4_value", value_q, (i >= 3) ? 32'hDEAD_BEEF : 32'h0BAD_F00D);
    end
    en = 1'b1;
    step();
    chk("t4_res_d", 32'(digit_sel), 32'd5);
    chk("t4_res_a", 32'(anode_n), 32'hDF);
    chk("t4_res_v", value_q, 32'hDEAD_BEEF);
    step();
    chk("t4_res_d2", 32'(digit_sel), 32'd5);
    step();
    chk("t4_res_d3", 32'(digit_sel), 32'd6);
    chk("t4_res_a3", 32'(anode_n), 32'hBF);

    // 5: reset with a pending load discards it
    load = 1'b1; value = 32'hCAFE_0001; step(); load = 1'b0;
    chk("t5_pend", value_q, 32'hDEAD_BEEF);
    rst = 1'b1; step();
    chk("t5_digit", 32'(digit_sel), 32'd0);
    chk("t5_value", value_q, 32'd0);
    chk("t5_anode", 32'(anode_n), 32'hFF);
    chk("t5_frame", 32'(frame_tick), 32'd0);
    rst = 1'b0; n = 0;
    repeat (32) step();
    chk("t5_wrap_f", 32'(frame_tick), 32'd1);
    chk("t5_wrap_v", value_q, 32'd0);

    // load in the first cycle after reset applies immediately
    rst = 1'b1; step(); rst = 1'b0;
    n = 0; load = 1'b1; value = 32'h0000_0042; step(); load = 1'b0;
    chk("t5_first", value_q, 32'h0000_0042);
    chk("t5_first_a", 32'(anode_n), 32'hFE);

    // 6: anode pattern for 0x42, then for 0 (loaded mid-frame, applied at n=32)
    while (n < 63) begin
      if (n == 9) begin load = 1'b1; value = 32'd0; end
      step();
      load = 1'b0;
      d = (n / 4) % 8;
`ifdef LEADING_ZERO_BLANK_EN
      if (n >= 32) exp_a = (d == 0) ? exp_an(d) : 8'hFF;
      else         exp_a = (d <= 1) ? exp_an(d) : 8'hFF;
`else
      exp_a = exp_an(d);
`endif
      chk("t6_anode", 32'(anode_n), 32'(exp_a));
      chk("t6_value", value_q, (n >= 32) ? 32'd0 : 32'h0000_0042);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
